// File: rtl/accum_cpu_controller_if.sv
// Control/status bus between the accumulator CPU controller and its datapath.
// The master side drives the datapath controls; the slave side returns RAM data and the A flags.
interface accum_cpu_controller_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [1:0]        Asel;
    logic              Aload;
    logic              Sub;
    logic              MemWr;
    logic [ADDR_W-1:0] RAMAddress;
    logic [DATA_W-1:0] RAM_output;
    logic              Aeq0;
    logic              Apos;

    modport master (
        output Asel,
        output Aload,
        output Sub,
        output MemWr,
        output RAMAddress,
        input  RAM_output,
        input  Aeq0,
        input  Apos
    );

    modport slave (
        input  Asel,
        input  Aload,
        input  Sub,
        input  MemWr,
        input  RAMAddress,
        output RAM_output,
        output Aeq0,
        output Apos
    );
endinterface

// File: rtl/accum_cpu_controller.sv
// Fetch/decode/execute sequencer for the accumulator + 32x8 RAM datapath.
// All controls are Moore outputs of state, IR and PC; Aload in INPUT also follows Enter.
module accum_cpu_controller #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int PC_START = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enter,
    accum_cpu_controller_if.master dp,
    output logic                  Halt,
    output logic [2:0]            State
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_INPUT  = 3'b011,
        S_HALT   = 3'b100
    } state_e;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = ir_q[DATA_W-1 -: 3];
    assign operand = ir_q[ADDR_W-1:0];
    assign State   = state_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(PC_START);
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        dp.Asel       = 2'b00;
        dp.Aload      = 1'b0;
        dp.Sub        = 1'b0;
        dp.MemWr      = 1'b0;
        dp.RAMAddress = pc_q;
        Halt          = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = dp.RAM_output;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                dp.RAMAddress = operand;
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_INPUT) begin
                    state_d = S_INPUT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                dp.RAMAddress = operand;
                state_d       = S_FETCH;
                case (opcode)
                    OP_LOAD: begin
                        dp.Asel  = 2'b10;
                        dp.Aload = 1'b1;
                    end
                    OP_STORE: dp.MemWr = 1'b1;
                    OP_ADD:   dp.Aload = 1'b1;
                    OP_SUB: begin
                        dp.Sub   = 1'b1;
                        dp.Aload = 1'b1;
                    end
                    OP_JZ:   if (dp.Aeq0) pc_d = operand;
                    OP_JPOS: if (dp.Apos) pc_d = operand;
                    default: ;
                endcase
            end
            S_INPUT: begin
                dp.Asel  = 2'b01;
                dp.Aload = Enter;
                if (Enter) state_d = S_FETCH;
            end
            S_HALT: Halt = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_accum_cpu_controller.sv
// Bench: instruction-level reference generates the expected per-cycle controls,
// a small datapath model closes the loop around the controller.
module tb_accum_cpu_controller;
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Enter = 1'b0;
    logic       Halt;
    logic [2:0] State;
    logic [7:0] input_data = 8'h00;

    accum_cpu_controller_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    accum_cpu_controller #(.ADDR_W(5), .DATA_W(8), .PC_START(0)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Enter (Enter),
        .dp    (bus.master),
        .Halt  (Halt),
        .State (State)
    );

    always #5 Clock = ~Clock;

    logic [7:0] dp_ram [32];
    logic [7:0] init_ram [32];
    logic [7:0] dp_a;
    logic       dp_init = 1'b0;

    assign bus.RAM_output = dp_ram[bus.RAMAddress];
    assign bus.Aeq0       = (dp_a == 8'h00);
    assign bus.Apos       = ~dp_a[7];

    always @(posedge Clock) begin
        if (dp_init) begin
            for (int i = 0; i < 32; i++) dp_ram[i] <= init_ram[i];
            dp_a <= 8'h00;
        end else begin
            if (bus.MemWr) dp_ram[bus.RAMAddress] <= dp_a;
            if (bus.Aload) begin
                case (bus.Asel)
                    2'b00: dp_a <= bus.Sub ? dp_a - dp_ram[bus.RAMAddress]
                                           : dp_a + dp_ram[bus.RAMAddress];
                    2'b01: dp_a <= input_data;
                    2'b10: dp_a <= dp_ram[bus.RAMAddress];
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        logic [1:0] asel;
        logic       aload;
        logic       sub;
        logic       mw;
        logic       halt;
        logic [2:0] st;
        logic [4:0] addr;
        logic       care;
        logic       en;
        logic [7:0] din;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mram [32];
    logic [7:0] ma;
    logic [4:0] mpc;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] asel, input logic aload,
                        input logic sub, input logic mw, input logic halt,
                        input logic [2:0] st, input logic [4:0] addr,
                        input logic care, input logic en, input logic [7:0] din);
        exp_t e;
        e.asel = asel; e.aload = aload; e.sub = sub; e.mw = mw;
        e.halt = halt; e.st = st; e.addr = addr; e.care = care;
        e.en = en; e.din = din;
        q.push_back(e);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction-level reference: n instructions, or until HALT (+20 idle cycles).
    task automatic gen(input int n, input int fw, input int fdin);
        logic [7:0] ir;
        logic [2:0] op;
        logic [4:0] opa;
        logic [1:0] asel;
        logic       aload, sub, mw;
        logic [7:0] d;
        int         w;
        bit         halted = 0;
        q.delete();
        for (int i = 0; i < 32; i++) mram[i] = init_ram[i];
        ma  = 8'h00;
        mpc = 5'd0;
        for (int k = 0; k < n && !halted; k++) begin
            push(2'b00, 0, 0, 0, 0, 3'd0, mpc, 1, rb(), 8'($urandom));
            ir  = mram[mpc];
            mpc = mpc + 5'd1;
            op  = ir[7:5];
            opa = ir[4:0];
            push(2'b00, 0, 0, 0, 0, 3'd1, opa, 1, rb(), 8'($urandom));
            if (op == 3'd7) begin
                halted = 1;
                for (int j = 0; j < 20; j++)
                    push(2'b00, 0, 0, 0, 1, 3'd4, mpc, 1, rb(), 8'($urandom));
            end else if (op == 3'd4) begin
                w = (fw >= 0) ? fw : int'($urandom_range(0, 4));
                d = (fdin >= 0) ? 8'(fdin) : 8'($urandom);
                for (int j = 0; j < w; j++)
                    push(2'b01, 0, 0, 0, 0, 3'd3, 5'd0, 0, 0, 8'($urandom));
                push(2'b01, 1, 0, 0, 0, 3'd3, 5'd0, 0, 1, d);
                ma = d;
            end else begin
                asel = 2'b00; aload = 0; sub = 0; mw = 0;
                case (op)
                    3'd0: begin asel = 2'b10; aload = 1; ma = mram[opa]; end
                    3'd1: begin mw = 1; mram[opa] = ma; end
                    3'd2: begin aload = 1; ma = ma + mram[opa]; end
                    3'd3: begin aload = 1; sub = 1; ma = ma - mram[opa]; end
                    3'd5: if (ma == 8'h00) mpc = opa;
                    default: if (!ma[7]) mpc = opa;
                endcase
                push(asel, aload, sub, mw, 0, 3'd2, opa, 1, rb(), 8'($urandom));
            end
        end
    endtask

    task automatic cmp(input exp_t e);
        chk("ctl", {24'd0, bus.Asel, bus.Aload, bus.Sub, bus.MemWr, Halt, State},
            {24'd0, e.asel, e.aload, e.sub, e.mw, e.halt, e.st});
        if (e.care) chk("addr", {27'd0, bus.RAMAddress}, {27'd0, e.addr});
    endtask

    task automatic run_queue(input int k);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            e = q.pop_front();
            Enter = e.en;
            input_data = e.din;
            #1 cmp(e);
            cyc++;
            @(negedge Clock);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        dp_init = 1'b1;
        Enter = rb();
        #1 chk("reset_ctl", {24'd0, bus.Asel, bus.Aload, bus.Sub, bus.MemWr,
                             Halt, State}, 32'd0);
        chk("reset_addr", {27'd0, bus.RAMAddress}, 32'd0);
        @(negedge Clock);
        dp_init = 1'b0;
        Reset = 1'b1;
    endtask

    task automatic check_state();
        int diffs = 0;
        chk("A_vs_model", {24'd0, dp_a}, {24'd0, ma});
        for (int i = 0; i < 32; i++) if (dp_ram[i] !== mram[i]) diffs++;
        chk("ram_vs_model", diffs, 0);
    endtask

    task automatic clear_ram(input logic [7:0] fill);
        for (int i = 0; i < 32; i++) init_ram[i] = fill;
    endtask

    task automatic run_prog(input int n, input int fw, input int fdin);
        gen(n, fw, fdin);
        do_reset();
        run_queue(q.size());
        check_state();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        // LOAD 30 then HALT
        clear_ram(8'h00);
        init_ram[0] = 8'h1E; init_ram[1] = 8'hE0; init_ram[30] = 8'h05;
        run_prog(10, -1, -1);
        chk("load_A_lit", {24'd0, dp_a}, 32'h05);
        chk("load_pc_lit", {27'd0, mpc}, 32'd2);

        // LOAD 30, SUB 31, JZ 7: taken
        clear_ram(8'h00);
        init_ram[0] = 8'h1E; init_ram[1] = 8'h7F; init_ram[2] = 8'hA7;
        init_ram[3] = 8'hE0; init_ram[7] = 8'hE0;
        init_ram[30] = 8'h05; init_ram[31] = 8'h05;
        run_prog(10, -1, -1);
        chk("jz_taken_A", {24'd0, dp_a}, 32'h00);
        chk("jz_taken_pc", {27'd0, mpc}, 32'd8);

        // same, RAM[31]=4: not taken
        init_ram[31] = 8'h04;
        run_prog(10, -1, -1);
        chk("jz_not_A", {24'd0, dp_a}, 32'h01);
        chk("jz_not_pc", {27'd0, mpc}, 32'd4);

        // INPUT with 4 wait cycles, 0x9C, then JPOS 5 not taken
        clear_ram(8'h00);
        init_ram[0] = 8'h80; init_ram[1] = 8'hC5; init_ram[2] = 8'hE0;
        init_ram[5] = 8'hE0;
        run_prog(10, 4, 8'h9C);
        chk("input_A", {24'd0, dp_a}, 32'h9C);
        chk("jpos_not_pc", {27'd0, mpc}, 32'd3);

        // LOAD 30, STORE 29, HALT
        clear_ram(8'h00);
        init_ram[0] = 8'h1E; init_ram[1] = 8'h3D; init_ram[2] = 8'hE0;
        init_ram[30] = 8'h05; init_ram[29] = 8'h11;
        run_prog(10, -1, -1);
        chk("store_ram29", {24'd0, dp_ram[29]}, 32'h05);

        // reset asserted during STORE execute
        gen(2, -1, -1);
        do_reset();
        run_queue(q.size() - 1);
        e = q.pop_front();
        Enter = e.en;
        #1 chk("store_mw_before", {31'd0, bus.MemWr}, 32'd1);
        Reset = 1'b0;
        #1 chk("abort_mw", {31'd0, bus.MemWr}, 32'd0);
        chk("abort_state", {29'd0, State}, 32'd0);
        chk("abort_addr", {27'd0, bus.RAMAddress}, 32'd0);
        @(negedge Clock);
        chk("abort_ram29", {24'd0, dp_ram[29]}, 32'h11);
        chk("abort_A", {24'd0, dp_a}, 32'h05);
        Reset = 1'b1;

        // fall-through to HALT at 31
        clear_ram(8'h1E);
        init_ram[31] = 8'hE0;
        run_prog(40, -1, -1);
        chk("halt31_pc_wrap", {27'd0, mpc}, 32'd0);
        chk("halt31_A", {24'd0, dp_a}, 32'h1E);

        // not-taken JZ at 31 wraps PC to 0
        clear_ram(8'h1E);
        init_ram[31] = 8'hA5;
        run_prog(33, -1, -1);
        chk("wrap_pc", {27'd0, mpc}, 32'd1);

        // random programs
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < 32; i++) init_ram[i] = 8'($urandom);
            run_prog(40, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
